// File: rtl/iu_pkg.sv
// Shared definitions for the instruction unit: FSM state encoding and
// default widths used by both the IU (PC + instMem) and its controller.
package iu_pkg;

  localparam int IU_ADDR_W  = 5;
  localparam int IU_INSTR_W = 13;
  localparam int IU_OPC_W   = 4;
  localparam logic [IU_OPC_W-1:0] IU_HALT_OPC = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } iu_state_e;

endpackage

// File: rtl/iu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the instruction unit.
// Drives the PC and IR strobes, launches execute and counts retired instructions.
module iu_ctrl
  import iu_pkg::*;
#(
  parameter int ADDR_W  = IU_ADDR_W,
  parameter int INSTR_W = IU_INSTR_W,
  parameter int OPC_W   = IU_OPC_W,
  parameter logic [OPC_W-1:0] HALT_OPC = IU_HALT_OPC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [INSTR_W-1:0] instr,
  input  logic              stall,
  input  logic              exec_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pc_ce,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              ir_load,
  output logic              exec_start,
  output logic [OPC_W-1:0]  opcode,
  output logic [2:0]        state,
  output logic              halted,
  output logic [7:0]        retired
);

  iu_state_e        state_q, state_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic [7:0]       retired_q, retired_d;

  logic [OPC_W-1:0] instrOpc;
  logic             unusedInstrBits;

  assign instrOpc        = instr[INSTR_W-1 -: OPC_W];
  assign unusedInstrBits = ^instr[INSTR_W-OPC_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

  // A stalled cycle keeps the state and suppresses every strobe, so a held
  // exec_done is only accepted on the first unstalled EXEC cycle.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    retired_d  = retired_q;
    pc_ce      = 1'b0;
    pc_load    = 1'b0;
    ir_load    = 1'b0;
    exec_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!stall) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!stall) begin
          ir_load  = 1'b1;
          opcode_d = instrOpc;
          if (instrOpc == HALT_OPC) begin
            state_d = ST_HALT;
          end else begin
            exec_start = 1'b1;
            state_d    = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (!stall && exec_done) begin
          pc_load   = br_taken;
          pc_ce     = !br_taken;
          retired_d = retired_q + 8'd1;
          state_d   = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc_load_addr = pc_load ? br_target : '0;
  assign opcode       = opcode_q;
  assign state        = state_q;
  assign halted       = (state_q == ST_HALT);
  assign retired      = retired_q;

endmodule

// File: tb/tb_iu_ctrl.sv
// Directed self-checking bench for iu_ctrl: reset, sequencing, branch,
// stall, retire-counter wrap, reset mid-execute and HALT.
module tb_iu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] instr;
  logic        stall;
  logic        exec_done;
  logic        br_taken;
  logic [4:0]  br_target;
  logic        pc_ce;
  logic        pc_load;
  logic [4:0]  pc_load_addr;
  logic        ir_load;
  logic        exec_start;
  logic [3:0]  opcode;
  logic [2:0]  state;
  logic        halted;
  logic [7:0]  retired;

  int nChecks = 0;
  int nFails  = 0;

  iu_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .instr        (instr),
    .stall        (stall),
    .exec_done    (exec_done),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .pc_ce        (pc_ce),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .ir_load      (ir_load),
    .exec_start   (exec_start),
    .opcode       (opcode),
    .state        (state),
    .halted       (halted),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; instr = '0; stall = 1'b0;
    exec_done = 1'b0; br_taken = 1'b0; br_target = '0;
    repeat (2) @(negedge clk);
    nChecks++;
    if (state !== 3'd0) begin nFails++; $display("[TB] FAIL reset_state got %0d want 0", state); end
    nChecks++;
    if (retired !== 8'd0) begin nFails++; $display("[TB] FAIL reset_retired got %0d want 0", retired); end
    nChecks++;
    if (halted !== 1'b0 || opcode !== 4'd0) begin nFails++; $display("[TB] FAIL reset_halt_opc got %b/%h want 0/0", halted, opcode); end
    nChecks++;
    if ({pc_ce, pc_load, ir_load, exec_start} !== 4'b0000) begin
      nFails++; $display("[TB] FAIL reset_strobes got %b want 0000", {pc_ce, pc_load, ir_load, exec_start});
    end
    nextCycle();
    reset = 1'b1;
  endtask

  task automatic test_basic();
    start = 1'b1;
    @(negedge clk);
    nChecks++;
    if (state !== 3'd0) begin nFails++; $display("[TB] FAIL basic_idle got %0d want 0", state); end
    nextCycle();
    start = 1'b0; instr = 13'h0200;
    @(negedge clk);
    nChecks++;
    if (state !== 3'd1 || {pc_ce, pc_load, ir_load, exec_start} !== 4'b0000) begin
      nFails++; $display("[TB] FAIL basic_fetch got st=%0d str=%b want st=1 str=0000", state, {pc_ce, pc_load, ir_load, exec_start});
    end
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (state !== 3'd2 || {pc_ce, pc_load, ir_load, exec_start} !== 4'b0011) begin
      nFails++; $display("[TB] FAIL basic_decode got st=%0d str=%b want st=2 str=0011", state, {pc_ce, pc_load, ir_load, exec_start});
    end
    nextCycle();
    exec_done = 1'b1;
    @(negedge clk);
    nChecks++;
    if (state !== 3'd3 || opcode !== 4'h1 || {pc_ce, pc_load, ir_load, exec_start} !== 4'b1000) begin
      nFails++; $display("[TB] FAIL basic_exec got st=%0d opc=%h str=%b want st=3 opc=1 str=1000", state, opcode, {pc_ce, pc_load, ir_load, exec_start});
    end
    nextCycle();
    exec_done = 1'b0;
    @(negedge clk);
    nChecks++;
    if (state !== 3'd1 || retired !== 8'd1 || pc_ce !== 1'b0) begin
      nFails++; $display("[TB] FAIL basic_retire got st=%0d ret=%0d ce=%b want st=1 ret=1 ce=0", state, retired, pc_ce);
    end
  endtask

  task automatic test_branch();
    instr = 13'h0400;
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (exec_start !== 1'b1) begin nFails++; $display("[TB] FAIL branch_decode got exec_start=%b want 1", exec_start); end
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (state !== 3'd3 || pc_ce !== 1'b0 || pc_load !== 1'b0 || pc_load_addr !== 5'd0) begin
      nFails++; $display("[TB] FAIL branch_wait got st=%0d ce=%b ld=%b addr=%0d want st=3 ce=0 ld=0 addr=0", state, pc_ce, pc_load, pc_load_addr);
    end
    nextCycle();
    exec_done = 1'b1; br_taken = 1'b1; br_target = 5'd20;
    @(negedge clk);
    nChecks++;
    if (pc_load !== 1'b1 || pc_load_addr !== 5'd20 || pc_ce !== 1'b0) begin
      nFails++; $display("[TB] FAIL branch_load got ld=%b addr=%0d ce=%b want ld=1 addr=20 ce=0", pc_load, pc_load_addr, pc_ce);
    end
    nextCycle();
    exec_done = 1'b0; br_taken = 1'b0; br_target = '0;
    @(negedge clk);
    nChecks++;
    if (state !== 3'd1 || retired !== 8'd2) begin
      nFails++; $display("[TB] FAIL branch_retire got st=%0d ret=%0d want st=1 ret=2", state, retired);
    end
  endtask

  task automatic test_stall();
    instr = 13'h0600;
    nextCycle();
    nextCycle();
    stall = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nChecks++;
      if (state !== 3'd3 || retired !== 8'd2 || {pc_ce, pc_load, ir_load, exec_start} !== 4'b0000) begin
        nFails++; $display("[TB] FAIL stall_hold[%0d] got st=%0d ret=%0d str=%b want st=3 ret=2 str=0000", i, state, retired, {pc_ce, pc_load, ir_load, exec_start});
      end
      nextCycle();
    end
    stall = 1'b0;
    @(negedge clk);
    nChecks++;
    if (pc_ce !== 1'b1 || pc_load !== 1'b0) begin nFails++; $display("[TB] FAIL stall_release got ce=%b ld=%b want 1/0", pc_ce, pc_load); end
    nextCycle();
    exec_done = 1'b0;
    @(negedge clk);
    nChecks++;
    if (state !== 3'd1 || retired !== 8'd3 || pc_ce !== 1'b0) begin
      nFails++; $display("[TB] FAIL stall_retire got st=%0d ret=%0d ce=%b want st=1 ret=3 ce=0", state, retired, pc_ce);
    end
  endtask

  task automatic test_wrap();
    int ceCount = 0;
    instr = 13'h0200;
    for (int i = 0; i < 253; i++) begin
      start = (i == 100);
      nextCycle();
      start = 1'b0;
      if (i == 252) begin
        @(negedge clk);
        nChecks++;
        if (retired !== 8'd255) begin nFails++; $display("[TB] FAIL wrap_pre got %0d want 255", retired); end
      end
      nextCycle();
      exec_done = 1'b1;
      @(negedge clk);
      if (pc_ce === 1'b1) ceCount++;
      nextCycle();
      exec_done = 1'b0;
    end
    @(negedge clk);
    nChecks++;
    if (retired !== 8'd0 || state !== 3'd1) begin
      nFails++; $display("[TB] FAIL wrap_count got ret=%0d st=%0d want ret=0 st=1", retired, state);
    end
    nChecks++;
    if (ceCount != 253) begin nFails++; $display("[TB] FAIL wrap_pc_ce got %0d want 253", ceCount); end
  endtask

  task automatic test_reset_exec();
    instr = 13'h0200;
    nextCycle();
    nextCycle();
    exec_done = 1'b1;
    nextCycle();
    exec_done = 1'b0;
    @(negedge clk);
    nChecks++;
    if (retired !== 8'd1) begin nFails++; $display("[TB] FAIL rstexec_pre got %0d want 1", retired); end
    nextCycle();
    nextCycle();
    exec_done = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    nChecks++;
    if (state !== 3'd0 || retired !== 8'd0 || pc_ce !== 1'b0 || pc_load !== 1'b0) begin
      nFails++; $display("[TB] FAIL rstexec_async got st=%0d ret=%0d ce=%b ld=%b want 0/0/0/0", state, retired, pc_ce, pc_load);
    end
    nextCycle();
    nChecks++;
    if (state !== 3'd0 || retired !== 8'd0) begin
      nFails++; $display("[TB] FAIL rstexec_hold got st=%0d ret=%0d want 0/0", state, retired);
    end
    exec_done = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_halt();
    start = 1'b1;
    nextCycle();
    start = 1'b0; instr = 13'h1E00;
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (state !== 3'd2 || ir_load !== 1'b1 || exec_start !== 1'b0) begin
      nFails++; $display("[TB] FAIL halt_decode got st=%0d ir=%b es=%b want st=2 ir=1 es=0", state, ir_load, exec_start);
    end
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (state !== 3'd4 || halted !== 1'b1 || opcode !== 4'hF || {pc_ce, pc_load, ir_load, exec_start} !== 4'b0000) begin
      nFails++; $display("[TB] FAIL halt_enter got st=%0d h=%b opc=%h str=%b want st=4 h=1 opc=f str=0000", state, halted, opcode, {pc_ce, pc_load, ir_load, exec_start});
    end
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    nextCycle();
    @(negedge clk);
    nChecks++;
    if (state !== 3'd4 || halted !== 1'b1) begin
      nFails++; $display("[TB] FAIL halt_start_ignored got st=%0d h=%b want st=4 h=1", state, halted);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_exec();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
